// File: rtl/fifo_thresh.sv
// rtl/fifo_thresh.sv - single-clock FIFO with threshold flags, sticky errors and FWFT/registered read modes
module fifo_thresh #(
  parameter int DataWidth   = 8,
  parameter int Depth       = 8,
  parameter bit FWFT        = 1'b0,
  parameter int AlmostFull  = Depth - 2,
  parameter int AlmostEmpty = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [DataWidth-1:0]       i_wr_data,
  input  logic                       i_wr_en,
  input  logic                       i_rd_en,
  input  logic                       i_flush,
  input  logic                       i_clr_err,
  output logic [DataWidth-1:0]       o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(Depth);
  localparam logic [CW-1:0] AfC    = CW'(AlmostFull);
  localparam logic [CW-1:0] AeC    = CW'(AlmostEmpty);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 af_q, af_d;
  logic                 ae_q, ae_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wr_accept;
  logic                 rd_accept;

  // A flush swallows any same-cycle write or read, so neither is accepted
  assign wr_accept = i_wr_en & ~full_q & ~i_flush;
  assign rd_accept = i_rd_en & ~empty_q & ~i_flush;

  // Next-state pointers, count, and flags derived from the next count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == DepthC);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AfC);
    ae_d    = (count_d <= AeC);
    // A new error event outranks a same-cycle clear
    ovf_d   = (i_wr_en & full_q & ~i_flush) | (ovf_q & ~i_clr_err);
    udf_d   = (i_rd_en & empty_q & ~i_flush) | (udf_q & ~i_clr_err);
  end

  // Control and status registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents survive reset and flush, writes blocked during reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_accept) mem_q[wr_ptr_q] <= i_wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_rd_data  = mem_q[rd_ptr_q];
      assign o_rd_valid = ~empty_q;
    end else begin : g_reg
      logic [DataWidth-1:0] rd_data_q;
      logic                 rd_valid_q;
      // Registered read port: popped word appears the cycle after the read
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) rd_data_q <= mem_q[rd_ptr_q];
        end
      end
      assign o_rd_data  = rd_data_q;
      assign o_rd_valid = rd_valid_q;
    end
  endgenerate

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: doc/fifo_thresh.md
FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 SHALL provide parameter DataWidth, default 8: word width in bits.
REQ-002 SHALL provide parameter Depth, default 8: word capacity; power of two, >= 4.
REQ-003 SHALL provide parameter FWFT, default 0: 1 = first-word fall-through read mode, 0 = registered read mode.
REQ-004 SHALL provide parameter AlmostFull, default Depth-2: almost-full threshold; range 1..Depth-1.
REQ-005 SHALL provide parameter AlmostEmpty, default 2: almost-empty threshold; range 1..Depth-1.
REQ-006 SHALL provide ports, clock and reset first (CW = $clog2(Depth)+1):
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_wr_data  in  DataWidth  write word.
- i_wr_en  in  1  write request.
- i_rd_en  in  1  read request (FWFT=1: pop acknowledge).
- i_flush  in  1  discard all contents.
- i_clr_err  in  1  clear sticky error flags.
- o_rd_data  out  DataWidth  read word.
- o_rd_valid  out  1  o_rd_data holds a valid word.
- o_full  out  1  count == Depth.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AlmostFull.
- o_almost_empty  out  1  count <= AlmostEmpty.
- o_count  out  CW  stored words, 0..Depth.
- o_overflow  out  1  sticky: write attempted while full.
- o_underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 SHALL accept a write when i_wr_en=1 and o_full=0; i_wr_data stored at write pointer; pointer +1.
REQ-008 SHALL accept a read when i_rd_en=1 and o_empty=0; read pointer +1.
REQ-009 SHALL wrap each pointer Depth-1 -> 0; no gap, no duplicate location.
REQ-010 SHALL update o_count by +1 (write only), -1 (read only), 0 (both or neither) at each edge; never outside 0..Depth.
REQ-011 SHALL register all status flags from the next-state count, so flags and o_count change in the same cycle.
REQ-012 SHALL reject a write while full even if a read is accepted that cycle; read proceeds, count -1.
REQ-013 FWFT=0: SHALL drive o_rd_data with the popped word one cycle after an accepted read, pulse o_rd_valid high for that cycle, and otherwise hold o_rd_data at its last value with o_rd_valid=0.
REQ-014 FWFT=1: SHALL present the head word on o_rd_data with o_rd_valid = !o_empty; a written word appears the cycle after its write into an empty FIFO; an accepted read advances to the next word in the following cycle.
REQ-015 SHALL set o_overflow when i_wr_en=1 and o_full=0 is false (write rejected); SHALL set o_underflow when i_rd_en=1 and o_empty=1; both remain set until i_clr_err=1.
REQ-016 SHALL let a set condition win over i_clr_err in the same cycle.
REQ-017 i_flush=1: SHALL zero pointers and count at the next edge, ignore same-cycle writes/reads, flag no overflow/underflow that cycle, force o_rd_valid=0 next cycle; sticky flags and memory contents unchanged.
REQ-018 SHALL not reset or clear memory contents; only pointers, count, flags and output registers.

Reset
REQ-019 i_rst_n=0 at an edge SHALL set: pointers 0, o_count 0, o_empty 1, o_almost_empty 1, o_full 0, o_almost_full 0, o_overflow 0, o_underflow 0, o_rd_valid 0, o_rd_data 0 (FWFT=0).
REQ-020 Reset SHALL take priority over i_flush, i_clr_err, writes and reads; reset mid-operation discards all stored words.

Verification (DataWidth=8, Depth=8, AlmostFull=6, AlmostEmpty=2)
REQ-021 FWFT=0: write 0x11,0x22,0x33, then 3 reads -> o_rd_data 0x11,0x22,0x33 each one cycle after its read with o_rd_valid pulses; o_count 3->0; o_empty=1 at end.
REQ-022 Write 8 words -> o_almost_full=1 at count 6, o_full=1 at count 8; 9th write rejected, o_overflow=1, o_count=8; i_clr_err -> o_overflow=0.
REQ-023 At count 8, assert write+read together -> read accepted, write rejected, o_count=7, o_overflow=1.
REQ-024 FWFT=1: write 0xA5 into empty FIFO -> next cycle o_rd_valid=1, o_rd_data=0xA5 with no read; read -> o_empty=1, o_rd_valid=0; read while empty -> o_underflow=1.
REQ-025 Fill 5, i_flush with i_wr_en=1 -> next cycle o_count=0, o_empty=1, o_overflow unchanged; then 10 write/read pairs across wrap -> data order preserved.
REQ-026 Fill 4, assert i_rst_n=0 for one cycle -> all outputs at REQ-019 values; subsequent write/read returns the new word.
